adc_frame_capture: RTL and testbench

- Parametrised successor to the two-channel serial ADC controller.
- Drives a shared serial-ADC bus (adc_sclk, adc_cs_n) and captures N_CH parallel serial data lines per conversion.
- Runs PIXELS back-to-back conversions per frame after each start pulse (the sensor SI pulse) and buffers samples in a first-word-fall-through FIFO with a first-of-frame tag.
- Sits between the sensor/ADC pins and the SPI readout; flags frame completion and FIFO overflow.

---
 rtl/sync_fifo.sv | 47 ++++
 rtl/adc_frame_capture.sv | 150 +++++++++++++++
 tb/tb_adc_frame_capture.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO; head entry is presented combinationally on out_dat (zero when empty).
// Latency: a push into an empty FIFO is visible on out_vld/out_dat the cycle after the push.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // The extra pointer bit separates the full case from the empty case.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_vld = (wr_ptr != rd_ptr);
    assign in_rdy  = !full || out_rdy;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

// File: rtl/adc_frame_capture.sv
// Serial-ADC frame sequencer: runs PIXELS conversions per start pulse, captures N_CH lines, queues samples.
// Latency: 2*CLK_DIV + 2*CLK_DIV*(LEAD_BITS+DATA_W) + 1 cycles per conversion; sample visible the cycle after STORE.
// Backpressure: none toward the ADC; a sample arriving at a full FIFO is dropped and overflow is set.
module adc_frame_capture #(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 12,
    parameter int LEAD_BITS  = 4,
    parameter int CLK_DIV    = 2,
    parameter int PIXELS     = 128,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           fpga_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [N_CH-1:0]                serial_data,
    output logic                           adc_sclk,
    output logic                           adc_cs_n,
    output logic [N_CH*DATA_W-1:0]         out_data,
    output logic                           out_first,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overflow,
    output logic [$clog2(PIXELS+1)-1:0]    sample_count
);
    localparam int CNT_W = $clog2(PIXELS+1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_N  = 2*(LEAD_BITS+DATA_W);
    localparam int HP_W  = $clog2(HP_N);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV-1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HP_N-1);
    localparam logic [CNT_W-1:0] PIX_CNT  = CNT_W'(PIXELS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [DIV_W-1:0]       div_cnt;
    logic [HP_W-1:0]        hp_cnt;
    logic                   tick;
    logic [CNT_W-1:0]       count_inc;
    logic                   last_pix;
    logic                   store;
    logic                   fifo_in_rdy;
    logic [DATA_W-1:0]      shreg [N_CH];
    logic [N_CH*DATA_W-1:0] data_cat;

    assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign count_inc = sample_count + CNT_W'(1);
    assign last_pix  = (count_inc == PIX_CNT);
    assign store     = (state == ST_STORE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: if (tick) state_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && hp_cnt == HP_LAST) state_nxt = ST_HOLD;
            ST_HOLD:  if (tick) state_nxt = ST_STORE;
            ST_STORE: state_nxt = last_pix ? ST_IDLE : ST_SETUP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            hp_cnt       <= '0;
            adc_sclk     <= 1'b1;
            adc_cs_n     <= 1'b1;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            // Divider restarts on every state change so each state begins on a fresh half-period.
            if (state == ST_IDLE || state_nxt != state || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sample_count <= '0;
                        overflow     <= 1'b0;
                        adc_cs_n     <= 1'b0;
                        adc_sclk     <= 1'b1;
                        hp_cnt       <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        adc_sclk <= ~adc_sclk;
                        if (hp_cnt == HP_LAST) begin
                            hp_cnt   <= '0;
                            adc_cs_n <= 1'b1;
                        end else begin
                            hp_cnt <= hp_cnt + HP_W'(1);
                        end
                    end
                end
                ST_STORE: begin
                    sample_count <= count_inc;
                    if (!fifo_in_rdy) overflow <= 1'b1;
                    if (last_pix) frame_done <= 1'b1;
                    else          adc_cs_n   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Capture on the edge that raises sclk; lead bits shift out of the top.
    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) shreg[i] <= '0;
        end else if (state == ST_SHIFT && tick && !adc_sclk) begin
            for (int i = 0; i < N_CH; i++) shreg[i] <= {shreg[i][DATA_W-2:0], serial_data[i]};
        end
    end

    always_comb begin
        data_cat = '0;
        for (int i = 0; i < N_CH; i++) data_cat[i*DATA_W +: DATA_W] = shreg[i];
    end

    sync_fifo #(
        .WIDTH (N_CH*DATA_W+1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (fpga_clk),
        .arst_n   (reset),
        .in_vld   (store),
        .in_rdy   (fifo_in_rdy),
        .in_dat   ({(sample_count == '0), data_cat}),
        .out_vld  (out_valid),
        .out_rdy  (out_ready),
        .out_dat  ({out_first, out_data})
    );
endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench: default-parameter instance (frames, bus timing, overflow, reset abort) and a 4-channel instance.
module tb_adc_frame_capture;
    localparam int          FRAME_A  = 128*69;
    localparam int          CS_LOW_A = 66;        // SETUP 2 cycles + SHIFT 64 cycles
    localparam int          FRAME_B  = 3*35;
    localparam logic [23:0] EXP_A    = {12'h555, 12'hAAA};
    localparam logic [55:0] EXP_B    = {14'h3A5C, 14'h0F0F, 14'h2BCD, 14'h1234};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, ready_a;
    logic [1:0]  ser_a = '0;
    logic        sclk_a, cs_n_a, first_a, valid_a, busy_a, fd_a, ovf_a;
    logic [23:0] data_a;
    logic [7:0]  cnt_a;

    logic        rst_b, start_b, ready_b;
    logic [3:0]  ser_b = '0;
    logic        sclk_b, cs_n_b, first_b, valid_b, busy_b, fd_b, ovf_b;
    logic [55:0] data_b;
    logic [1:0]  cnt_b;

    adc_frame_capture dut_a (
        .fpga_clk(clk), .reset(rst_a), .start(start_a), .serial_data(ser_a),
        .adc_sclk(sclk_a), .adc_cs_n(cs_n_a), .out_data(data_a), .out_first(first_a),
        .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a), .frame_done(fd_a),
        .overflow(ovf_a), .sample_count(cnt_a)
    );

    adc_frame_capture #(
        .N_CH(4), .DATA_W(14), .LEAD_BITS(2), .CLK_DIV(1), .PIXELS(3), .FIFO_DEPTH(16)
    ) dut_b (
        .fpga_clk(clk), .reset(rst_b), .start(start_b), .serial_data(ser_b),
        .adc_sclk(sclk_b), .adc_cs_n(cs_n_b), .out_data(data_b), .out_first(first_b),
        .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b), .frame_done(fd_b),
        .overflow(ovf_b), .sample_count(cnt_b)
    );

    // ADC models: next bit (MSB first) driven after each falling sclk while selected.
    logic [15:0] wa0 = 16'h0AAA, wa1 = 16'h0555;
    logic [15:0] wb0 = 16'hD234, wb1 = 16'hABCD, wb2 = 16'h4F0F, wb3 = 16'h3A5C;
    int fall_a = 0, fall_b = 0;

    always @(negedge sclk_a or posedge cs_n_a) begin
        if (cs_n_a) fall_a = 0;
        else if (fall_a < 16) begin
            ser_a[0] = wa0[15-fall_a];
            ser_a[1] = wa1[15-fall_a];
            fall_a++;
        end
    end

    always @(negedge sclk_b or posedge cs_n_b) begin
        if (cs_n_b) fall_b = 0;
        else if (fall_b < 16) begin
            ser_b[0] = wb0[15-fall_b];
            ser_b[1] = wb1[15-fall_b];
            ser_b[2] = wb2[15-fall_b];
            ser_b[3] = wb3[15-fall_b];
            fall_b++;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus timing monitor on dut_a
    logic bus_en = 1'b0;
    logic sclk_prev = 1'b1;
    int low_run, falls, since_fall, conv_seen, bad_cs, bad_falls, bad_gap, hi_bad;
    always @(negedge clk) begin
        if (!bus_en) begin
            low_run = 0; falls = 0; since_fall = 0; conv_seen = 0;
            bad_cs = 0; bad_falls = 0; bad_gap = 0; hi_bad = 0; sclk_prev = 1'b1;
        end else begin
            if (!cs_n_a) begin
                low_run++;
                since_fall++;
                if (sclk_prev && !sclk_a) begin
                    if (falls > 0 && since_fall != 4) bad_gap++;
                    falls++;
                    since_fall = 0;
                end
            end else begin
                if (!sclk_a) hi_bad++;
                if (low_run > 0) begin
                    conv_seen++;
                    if (low_run != CS_LOW_A) bad_cs++;
                    if (falls != 16) bad_falls++;
                end
                low_run = 0;
                falls = 0;
            end
            sclk_prev = sclk_a;
        end
    end

    // Pop monitor on dut_a
    logic pop_en = 1'b0;
    int pops, bad_dat, first_cnt, first_bad;
    always @(negedge clk) begin
        if (!pop_en) begin
            pops = 0; bad_dat = 0; first_cnt = 0; first_bad = 0;
        end else if (valid_a && ready_a) begin
            if (data_a !== EXP_A) bad_dat++;
            if (first_a) begin
                first_cnt++;
                if (pops != 0) first_bad++;
            end else if (pops == 0) first_bad++;
            pops++;
        end
    end

    logic done_en = 1'b0;
    int done_cnt;
    always @(negedge clk) begin
        if (!done_en) done_cnt = 0;
        else if (fd_a) done_cnt++;
    end

    logic ovf_en = 1'b0;
    logic ovf16, ovf17;
    always @(negedge clk) begin
        if (!ovf_en) begin
            ovf16 = 1'b1; ovf17 = 1'b0;
        end else begin
            if (cnt_a == 8'd16) ovf16 = ovf_a;
            if (cnt_a == 8'd17) ovf17 = ovf_a;
        end
    end

    logic q_en = 1'b0;
    int quiet_bad;
    always @(negedge clk) begin
        if (!q_en) quiet_bad = 0;
        else if (valid_a || !cs_n_a || busy_a || fd_a) quiet_bad++;
    end

    task automatic wait_done(input bit sel_b, input bit poke, output int cyc,
                             output logic bsy_at, output logic bsy_prev);
        logic fd, bsy;
        cyc = -1; bsy_at = 1'b1; bsy_prev = 1'b0;
        for (int n = 1; n <= 20000; n++) begin
            @(posedge clk); #1;
            fd  = sel_b ? fd_b : fd_a;
            bsy = sel_b ? busy_b : busy_a;
            if (fd) begin
                cyc = n;
                bsy_at = bsy;
                break;
            end
            bsy_prev = bsy;
            start_a = poke && (n % 500 == 250);
        end
        start_a = 1'b0;
    endtask

    int   cyc, k;
    logic bat, bpr;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk_a, 1'b1);
        chk("rst_cs_n", cs_n_a, 1'b1);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data", data_a, 24'h0);
        chk("rst_first", first_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", fd_a, 1'b0);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_count", cnt_a, 8'd0);
        chk("rst_b_cs_n", cs_n_b, 1'b1);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_cs_n", cs_n_a, 1'b1);
        chk("idle_busy", busy_a, 1'b0);

        // Frame 1: free-flowing consumer, start poked while busy
        ready_a = 1'b1; bus_en = 1'b1; pop_en = 1'b1; done_en = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("f1_busy_on_start", busy_a, 1'b1);
        chk("f1_cs_low_on_start", cs_n_a, 1'b0);
        wait_done(1'b0, 1'b1, cyc, bat, bpr);
        chk("f1_done_cycles", cyc, FRAME_A);
        chk("f1_busy_at_done", bat, 1'b0);
        chk("f1_busy_before_done", bpr, 1'b1);
        chk("f1_count", cnt_a, 8'd128);
        @(posedge clk); #1;
        chk("f1_done_one_cycle", fd_a, 1'b0);
        chk("f1_fifo_drained", valid_a, 1'b0);
        chk("f1_done_pulses", done_cnt, 1);
        chk("f1_pops", pops, 128);
        chk("f1_bad_data", bad_dat, 0);
        chk("f1_first_count", first_cnt, 1);
        chk("f1_first_position", first_bad, 0);
        chk("bus_conversions", conv_seen, 128);
        chk("bus_cs_low_len", bad_cs, 0);
        chk("bus_fall_count", bad_falls, 0);
        chk("bus_fall_gap", bad_gap, 0);
        chk("bus_sclk_high_idle", hi_bad, 0);
        bus_en = 1'b0; pop_en = 1'b0; done_en = 1'b0;

        // Frame 2: started the cycle after frame_done, consumer stalled
        ready_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("f2_count_cleared", cnt_a, 8'd0);
        chk("f2_ovf_clear", ovf_a, 1'b0);
        ovf_en = 1'b1;
        wait_done(1'b0, 1'b0, cyc, bat, bpr);
        chk("f2_done_cycles", cyc, FRAME_A);
        chk("f2_count", cnt_a, 8'd128);
        chk("f2_overflow", ovf_a, 1'b1);
        chk("f2_ovf_at_16", ovf16, 1'b0);
        chk("f2_ovf_at_17", ovf17, 1'b1);
        chk("f2_valid", valid_a, 1'b1);
        ovf_en = 1'b0;
        pop_en = 1'b1; ready_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ready_a = 1'b0;
        chk("f2_retained", pops, 16);
        chk("f2_bad_data", bad_dat, 0);
        chk("f2_first_count", first_cnt, 1);
        chk("f2_first_position", first_bad, 0);
        chk("f2_empty", valid_a, 1'b0);
        chk("f2_ovf_sticky", ovf_a, 1'b1);
        pop_en = 1'b0;

        // Frame 3: start clears overflow, then reset mid-SHIFT of sample 5
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("f3_start_clears_ovf", ovf_a, 1'b0);
        k = 0;
        while (cnt_a != 8'd5 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("f3_reached_5", cnt_a, 8'd5);
        ready_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ready_a = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("f3_pre_rst_cs", cs_n_a, 1'b0);
        chk("f3_pre_rst_valid", valid_a, 1'b1);
        #1 rst_a = 1'b0;
        #1;
        chk("abort_cs_n", cs_n_a, 1'b1);
        chk("abort_sclk", sclk_a, 1'b1);
        chk("abort_valid", valid_a, 1'b0);
        chk("abort_count", cnt_a, 8'd0);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_data", data_a, 24'h0);
        @(negedge clk);
        rst_a = 1'b1;
        q_en = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_quiet", quiet_bad, 0);
        q_en = 1'b0;

        // 4-channel instance
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_done(1'b1, 1'b0, cyc, bat, bpr);
        chk("b_done_cycles", cyc, FRAME_B);
        chk("b_busy_at_done", bat, 1'b0);
        chk("b_count", cnt_b, 2'd3);
        chk("b_overflow", ovf_b, 1'b0);
        chk("b_valid0", valid_b, 1'b1);
        chk("b_data0", data_b, EXP_B);
        chk("b_first0", first_b, 1'b1);
        ready_b = 1'b1;
        @(posedge clk); #1;
        chk("b_data1", data_b, EXP_B);
        chk("b_first1", first_b, 1'b0);
        @(posedge clk); #1;
        chk("b_data2", data_b, EXP_B);
        chk("b_first2", first_b, 1'b0);
        @(posedge clk); #1;
        chk("b_empty", valid_b, 1'b0);
        ready_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
